// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings and default sizing
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   typedef enum logic [1:0] {
      PARITY_NONE,
      PARITY_EVEN,
      PARITY_ODD
   } parity_mode_t;

   localparam int DEFAULT_DATA_WIDTH    = 8;
   localparam int DEFAULT_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - generic first-word-fall-through FIFO with occupancy level
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int width = DEFAULT_DATA_WIDTH + 1,
   parameter int depth = DEFAULT_RX_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [width-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [width-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(depth):0]   level
);

   localparam int aw = $clog2(depth);
   localparam logic [aw:0]   full_lvl = (aw+1)'(depth);
   localparam logic [aw-1:0] ptr_one  = (aw)'(1);

   logic [width-1:0] mem [depth];
   logic [aw-1:0]    wr_ptr;
   logic [aw-1:0]    rd_ptr;
   logic [aw:0]      count;
   logic             do_wr;
   logic             do_rd;

   // A pop frees the slot a full-FIFO write needs; a pop on empty is simply dropped.
   assign do_rd = rd_en & (count != '0);
   assign do_wr = wr_en & ((count != full_lvl) | do_rd);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + ptr_one;
         if (do_rd) rd_ptr <= rd_ptr + ptr_one;
         if (do_wr && !do_rd)      count <= count + 1'b1;
         else if (do_rd && !do_wr) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Storage is not reset, so the head is gated to zero whenever nothing is queued.
   assign rd_data = (count == '0) ? '0 : mem[rd_ptr];
   assign empty   = (count == '0);
   assign full    = (count == full_lvl);
   assign level   = count;

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive character buffer with sticky overflow and framing-error count
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int data_width = DEFAULT_DATA_WIDTH,
   parameter int depth      = DEFAULT_RX_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_done,
   input  logic [data_width-1:0]    rx_data,
   input  logic                     rx_parity_error,
   input  logic                     rx_framing_error,
   input  logic                     rd_en,
   input  logic                     clr_flags,
   output logic [data_width-1:0]    rd_data,
   output logic                     rd_parity_error,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(depth):0]   level,
   output logic                     overflow,
   output logic [7:0]               frame_err_count
);

   logic                  done_q;
   logic                  done_armed;
   logic                  fe_q;
   logic                  wr;
   logic                  fe_edge;
   logic                  ovf_evt;
   logic [data_width:0]   head;

   // done_armed blocks a done level that is already high when reset releases.
   assign wr      = rx_done & ~done_q & done_armed;
   assign fe_edge = rx_framing_error & ~fe_q;
   assign ovf_evt = wr & full & ~rd_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q          <= 1'b0;
         done_armed      <= 1'b0;
         fe_q            <= 1'b0;
         overflow        <= 1'b0;
         frame_err_count <= 8'd0;
      end else begin
         done_q <= rx_done;
         fe_q   <= rx_framing_error;
         if (!rx_done) done_armed <= 1'b1;

         if (ovf_evt)        overflow <= 1'b1;
         else if (clr_flags) overflow <= 1'b0;

         if (fe_edge) begin
            if (clr_flags)                     frame_err_count <= 8'd1;
            else if (frame_err_count != 8'hFF) frame_err_count <= frame_err_count + 8'd1;
         end else if (clr_flags) begin
            frame_err_count <= 8'd0;
         end
      end
   end

   uart_sync_fifo #(
      .width (data_width + 1),
      .depth (depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr),
      .wr_data ({rx_parity_error, rx_data}),
      .rd_en   (rd_en),
      .rd_data (head),
      .empty   (empty),
      .full    (full),
      .level   (level)
   );

   assign rd_data         = head[data_width-1:0];
   assign rd_parity_error = head[data_width];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and randomized checks of uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx_done = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_parity_error = 1'b0;
   logic          rx_framing_error = 1'b0;
   logic          rd_en = 1'b0;
   logic          clr_flags = 1'b0;
   logic [DW-1:0] rd_data;
   logic          rd_parity_error;
   logic          empty;
   logic          full;
   logic [4:0]    level;
   logic          overflow;
   logic [7:0]    frame_err_count;

   int checks   = 0;
   int failures = 0;

   uart_rx_fifo #(.data_width(DW), .depth(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .rx_done          (rx_done),
      .rx_data          (rx_data),
      .rx_parity_error  (rx_parity_error),
      .rx_framing_error (rx_framing_error),
      .rd_en            (rd_en),
      .clr_flags        (clr_flags),
      .rd_data          (rd_data),
      .rd_parity_error  (rd_parity_error),
      .empty            (empty),
      .full             (full),
      .level            (level),
      .overflow         (overflow),
      .frame_err_count  (frame_err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of {parity, data}, plus the previous done/framing levels.
   logic [DW:0] m_q[$];
   bit          m_prev_done, m_seen_low, m_prev_fe, m_ovf;
   int          m_cnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q.delete();
         m_prev_done = 0; m_seen_low = 0; m_prev_fe = 0; m_ovf = 0; m_cnt = 0;
      end else begin
         bit w, p, drop, fe_rise;
         w       = rx_done && !m_prev_done && m_seen_low;
         p       = rd_en && (m_q.size() > 0);
         drop    = w && (m_q.size() == DEPTH) && !p;
         fe_rise = rx_framing_error && !m_prev_fe;
         if (p) void'(m_q.pop_front());
         if (w && !drop) m_q.push_back({rx_parity_error, rx_data});
         if (drop) m_ovf = 1; else if (clr_flags) m_ovf = 0;
         if (fe_rise) m_cnt = clr_flags ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
         else if (clr_flags) m_cnt = 0;
         m_prev_done = rx_done;
         if (!rx_done) m_seen_low = 1;
         m_prev_fe = rx_framing_error;
      end
   end

   always @(negedge clk) begin
      chk("empty", empty, m_q.size() == 0);
      chk("full", full, m_q.size() == DEPTH);
      chk("level", level, m_q.size());
      chk("overflow", overflow, m_ovf);
      chk("frame_err_count", frame_err_count, m_cnt);
      if (m_q.size() > 0) begin
         chk("rd_data", rd_data, m_q[0][DW-1:0]);
         chk("rd_parity_error", rd_parity_error, m_q[0][DW]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic p);
      rx_data = d; rx_parity_error = p; rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      tick();
   endtask

   task automatic pulse_clr();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
   endtask

   initial begin
      int rd_pct;
      // Reset values
      tick();
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_level", level, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_pe", rd_parity_error, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_fec", frame_err_count, 0);
      @(negedge clk) rst = 1'b1;
      tick(); tick();

      // Long done level writes once
      rx_data = 8'hA5; rx_done = 1'b1;
      tick();
      chk("t1_level_n1", level, 1);
      chk("t1_data_n1", rd_data, 8'hA5);
      repeat (15) tick();
      chk("t1_level_after16", level, 1);
      rx_done = 1'b0;
      tick();
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      chk("t1_empty_after_pop", empty, 1);

      // Fill, overflow, drain in order
      for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
      chk("t2_full", full, 1);
      chk("t2_level", level, 16);
      send(8'hFF, 1'b0);
      chk("t2_overflow", overflow, 1);
      chk("t2_level_after_drop", level, 16);
      rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t2_drain", rd_data, i);
         tick();
      end
      rd_en = 1'b0;
      chk("t2_empty", empty, 1);

      // Write and pop together while full
      pulse_clr();
      for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0);
      rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
      tick();
      rx_done = 1'b0; rd_en = 1'b0;
      chk("t3_no_overflow", overflow, 0);
      chk("t3_level", level, 16);
      rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("t3_drain", rd_data, (i < 15) ? 8'h21 + i : 8'h55);
         tick();
      end
      rd_en = 1'b0;

      // Parity flag travels with its entry
      send(8'h3C, 1'b1);
      send(8'h3D, 1'b0);
      chk("t4_pe_first", rd_parity_error, 1);
      chk("t4_data_first", rd_data, 8'h3C);
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      chk("t4_pe_second", rd_parity_error, 0);
      chk("t4_data_second", rd_data, 8'h3D);
      rd_en = 1'b1; tick(); rd_en = 1'b0;

      // Framing-error edges, clear collision, saturation
      for (int i = 0; i < 3; i++) begin
         rx_framing_error = 1'b1; tick(); rx_framing_error = 1'b0; tick();
      end
      chk("t5_fec3", frame_err_count, 3);
      rx_framing_error = 1'b1; clr_flags = 1'b1; tick();
      rx_framing_error = 1'b0; clr_flags = 1'b0; tick();
      chk("t5_fec_clr_edge", frame_err_count, 1);
      for (int i = 0; i < 260; i++) begin
         rx_framing_error = 1'b1; tick(); rx_framing_error = 1'b0; tick();
      end
      chk("t5_fec_sat", frame_err_count, 255);
      chk("t5_no_entry", empty, 1);
      pulse_clr();
      chk("t5_fec_cleared", frame_err_count, 0);

      // Reset mid-operation with done held high
      for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 1'b0);
      rx_data = 8'h44; rx_done = 1'b1;
      tick();
      chk("t6_level5", level, 5);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_empty", empty, 1);
      chk("t6_async_level", level, 0);
      tick(); tick();
      @(negedge clk) rst = 1'b1;
      tick(); tick(); tick();
      chk("t6_no_write_held", level, 0);
      rx_done = 1'b0; tick();
      rx_done = 1'b1; rx_data = 8'h77; tick();
      chk("t6_write_after_rearm", level, 1);
      chk("t6_data_after_rearm", rd_data, 8'h77);
      rx_done = 1'b0; tick();

      // Randomized traffic against the model
      rd_pct = 30;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 500 == 0) rd_pct = (cyc / 500 % 3 == 0) ? 5 : ((cyc / 500 % 3 == 1) ? 30 : 80);
         if (rx_done) begin
            if ($urandom_range(0, 3) == 0) rx_done = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            rx_done = 1'b1;
            rx_data = 8'($urandom);
            rx_parity_error = 1'($urandom);
         end
         rd_en = ($urandom_range(0, 99) < rd_pct);
         if ($urandom_range(0, 3) == 0) rx_framing_error = ~rx_framing_error;
         clr_flags = ($urandom_range(0, 49) == 0);
         if (cyc % 1000 == 700) begin
            #3 rst = 1'b0;
            @(negedge clk);
            @(negedge clk) rst = 1'b1;
         end
         tick();
      end
      rx_done = 1'b0; rd_en = 1'b0; clr_flags = 1'b0; rx_framing_error = 1'b0;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
